// File: rtl/cu_fsm.sv
// Purpose : multicycle control unit for the OTTER RV32I core (fetch / exec / load wb / irq entry).
// Latency : non-load 2 cycles, load 3 cycles, interrupt entry +1 cycle; outputs decode state (+opcode in EXEC).
// Backpr. : none; instruction boundaries are fixed by the state sequence, irq waits in intr_pend.
// Ports   : CLK, RST_N (async active-low) | intr, mie, opcode, func3 in |
//           pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec out.
module cu_fsm #(
  parameter int unsigned INIT_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       intr,
  input  logic       mie,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  output logic       pcWrite,
  output logic       regWrite,
  output logic       memWE2,
  output logic       memRDEN1,
  output logic       memRDEN2,
  output logic       reset,
  output logic       csr_WE,
  output logic       int_taken,
  output logic       mret_exec
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       intr_pend;
  logic       take;

  // A request seen on this very edge counts, as does one latched earlier.
  assign take = (intr | intr_pend) & mie;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_INIT;
      cnt       <= 4'd0;
      intr_pend <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          // intr is deliberately ignored while the core is held in reset.
          if (cnt == INIT_LAST) begin
            state <= ST_FETCH;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_FETCH: begin
          state     <= ST_EXEC;
          intr_pend <= intr_pend | intr;
        end
        ST_EXEC: begin
          if (opcode == OP_LOAD) begin
            // a load is not an instruction boundary until its writeback
            state     <= ST_WB;
            intr_pend <= intr_pend | intr;
          end else if (take) begin
            state     <= ST_INTR;
            intr_pend <= 1'b0;  // clearing beats a simultaneous new intr
          end else begin
            state     <= ST_FETCH;
            intr_pend <= intr_pend | intr;
          end
        end
        ST_WB: begin
          if (take) begin
            state     <= ST_INTR;
            intr_pend <= 1'b0;
          end else begin
            state     <= ST_FETCH;
            intr_pend <= intr_pend | intr;
          end
        end
        ST_INTR: begin
          state     <= ST_FETCH;
          intr_pend <= intr_pend | intr;
        end
        default: begin
          state <= ST_INIT;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Outputs follow the state register directly, so an async reset pulls
  // every enable low (and reset high) without waiting for a clock edge.
  always_comb begin
    pcWrite   = 1'b0;
    regWrite  = 1'b0;
    memWE2    = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    reset     = 1'b0;
    csr_WE    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    case (state)
      ST_INIT:  reset = 1'b1;
      ST_FETCH: memRDEN1 = 1'b1;
      ST_EXEC: begin
        case (opcode)
          OP_LOAD: memRDEN2 = 1'b1;
          OP_STORE: begin
            memWE2  = 1'b1;
            pcWrite = 1'b1;
          end
          OP_BRANCH: pcWrite = 1'b1;
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: begin
            pcWrite  = 1'b1;
            regWrite = 1'b1;
          end
          OP_SYS: begin
            pcWrite = 1'b1;
            if (func3 == 3'b000) begin
              mret_exec = 1'b1;
            end else begin
              regWrite = 1'b1;
              csr_WE   = 1'b1;
            end
          end
          // illegal opcodes just advance the PC
          default: pcWrite = 1'b1;
        endcase
      end
      ST_WB: begin
        regWrite = 1'b1;
        pcWrite  = 1'b1;
      end
      ST_INTR: begin
        int_taken = 1'b1;
        pcWrite   = 1'b1;
      end
      default: reset = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_cu_fsm.sv
// Purpose : scoreboard bench for cu_fsm; per-cycle stimulus and expected output vector queued together.
// Latency : one queue entry per clock; inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpr. : none.
module tb_cu_fsm;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       intr = 1'b0;
  logic       mie = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] func3 = 3'd0;
  logic       pcWrite, regWrite, memWE2, memRDEN1, memRDEN2;
  logic       reset, csr_WE, int_taken, mret_exec;

  int checks = 0;
  int errors = 0;

  cu_fsm #(.INIT_CYCLES(2)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .intr     (intr),
    .mie      (mie),
    .opcode   (opcode),
    .func3    (func3),
    .pcWrite  (pcWrite),
    .regWrite (regWrite),
    .memWE2   (memWE2),
    .memRDEN1 (memRDEN1),
    .memRDEN2 (memRDEN2),
    .reset    (reset),
    .csr_WE   (csr_WE),
    .int_taken(int_taken),
    .mret_exec(mret_exec)
  );

  always #5 CLK = ~CLK;

  // {reset, memRDEN1, memRDEN2, memWE2, pcWrite, regWrite, csr_WE, int_taken, mret_exec}
  logic [8:0] outs;
  assign outs = {reset, memRDEN1, memRDEN2, memWE2, pcWrite, regWrite, csr_WE, int_taken, mret_exec};

  localparam logic [8:0] E_RST   = 9'b1_0000_0000;
  localparam logic [8:0] E_FETCH = 9'b0_1000_0000;
  localparam logic [8:0] E_ALU   = 9'b0_0001_1000;
  localparam logic [8:0] E_LW    = 9'b0_0100_0000;
  localparam logic [8:0] E_WB    = 9'b0_0001_1000;
  localparam logic [8:0] E_SW    = 9'b0_0011_0000;
  localparam logic [8:0] E_PC    = 9'b0_0001_0000;
  localparam logic [8:0] E_INTR  = 9'b0_0001_0010;
  localparam logic [8:0] E_MRET  = 9'b0_0001_0001;
  localparam logic [8:0] E_CSR   = 9'b0_0001_1100;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [6:0] OP_BAD  = 7'b0000000;

  typedef struct {
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] f3;
    logic       irq;
    logic       en;
    logic [8:0] exp;
    string      name;
  } item_t;

  item_t sb[$];

  task automatic push(input logic r, input logic [6:0] op, input logic [2:0] f3,
                      input logic irq, input logic en, input logic [8:0] exp, input string name);
    item_t it;
    it.rst_n = r; it.op = op; it.f3 = f3; it.irq = irq; it.en = en; it.exp = exp; it.name = name;
    sb.push_back(it);
  endtask

  task automatic test_reset();
    item_t it;
    push(0, OP_BAD, 3'd0, 0, 0, E_RST,   "rst_hold0");
    push(0, OP_BAD, 3'd0, 0, 0, E_RST,   "rst_hold1");
    push(0, OP_BAD, 3'd0, 1, 0, E_RST,   "rst_hold2");
    push(1, OP_BAD, 3'd0, 1, 1, E_RST,   "init_c0");
    push(1, OP_BAD, 3'd0, 0, 0, E_RST,   "init_c1");
    push(1, OP_BAD, 3'd0, 0, 0, E_FETCH, "first_fetch");
    push(1, OP_BAD, 3'd0, 0, 1, E_PC,    "illegal_exec");
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(posedge CLK); #1;
      RST_N = it.rst_n; opcode = it.op; func3 = it.f3; intr = it.irq; mie = it.en;
      @(negedge CLK);
      checks++;
      if (outs !== it.exp) begin
        errors++;
        $display("FAIL %s: outputs %b, expected %b", it.name, outs, it.exp);
      end
    end
  endtask

  task automatic test_addi_lw();
    item_t it;
    push(1, OP_ADDI, 3'd0, 0, 0, E_FETCH, "addi_fetch");
    push(1, OP_ADDI, 3'd0, 0, 0, E_ALU,   "addi_exec");
    push(1, OP_LW,   3'd2, 0, 0, E_FETCH, "lw_fetch");
    push(1, OP_LW,   3'd2, 0, 0, E_LW,    "lw_exec");
    push(1, OP_LW,   3'd2, 0, 0, E_WB,    "lw_wb");
    push(1, OP_LUI,  3'd0, 0, 0, E_FETCH, "lui_fetch");
    push(1, OP_LUI,  3'd0, 0, 0, E_ALU,   "lui_exec");
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(posedge CLK); #1;
      RST_N = it.rst_n; opcode = it.op; func3 = it.f3; intr = it.irq; mie = it.en;
      @(negedge CLK);
      checks++;
      if (outs !== it.exp) begin
        errors++;
        $display("FAIL %s: outputs %b, expected %b", it.name, outs, it.exp);
      end
    end
  endtask

  task automatic test_sw_beq_csr();
    item_t it;
    push(1, OP_SW,  3'd2, 0, 0, E_FETCH, "sw_fetch");
    push(1, OP_SW,  3'd2, 0, 0, E_SW,    "sw_exec");
    push(1, OP_BEQ, 3'd0, 0, 0, E_FETCH, "beq_fetch");
    push(1, OP_BEQ, 3'd0, 0, 0, E_PC,    "beq_exec");
    push(1, OP_SYS, 3'd1, 0, 0, E_FETCH, "csrrw_fetch");
    push(1, OP_SYS, 3'd1, 0, 0, E_CSR,   "csrrw_exec");
    push(1, OP_ADD, 3'd0, 0, 0, E_FETCH, "add_fetch");
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(posedge CLK); #1;
      RST_N = it.rst_n; opcode = it.op; func3 = it.f3; intr = it.irq; mie = it.en;
      @(negedge CLK);
      checks++;
      if (outs !== it.exp) begin
        errors++;
        $display("FAIL %s: outputs %b, expected %b", it.name, outs, it.exp);
      end
    end
  endtask

  // Picks up in EXEC of the ADD fetched by the previous task.
  task automatic test_intr_enabled();
    item_t it;
    push(1, OP_ADD, 3'd0, 0, 1, E_ALU,   "add_exec");
    push(1, OP_ADD, 3'd0, 1, 1, E_FETCH, "irq_fetch");
    push(1, OP_ADD, 3'd0, 0, 1, E_ALU,   "irq_exec");
    push(1, OP_ADD, 3'd0, 0, 1, E_INTR,  "irq_entry");
    push(1, OP_ADD, 3'd0, 0, 1, E_FETCH, "post_irq_fetch");
    push(1, OP_ADD, 3'd0, 0, 1, E_ALU,   "post_irq_exec");
    push(1, OP_ADD, 3'd0, 0, 1, E_FETCH, "pend_cleared");
    // a load defers the interrupt to the end of its writeback
    push(1, OP_LW,  3'd2, 0, 1, E_LW,    "lw_irq_exec");
    push(1, OP_LW,  3'd2, 1, 1, E_WB,    "lw_irq_wb");
    push(1, OP_LW,  3'd2, 0, 1, E_INTR,  "lw_irq_entry");
    push(1, OP_ADD, 3'd0, 0, 0, E_FETCH, "lw_irq_fetch");
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(posedge CLK); #1;
      RST_N = it.rst_n; opcode = it.op; func3 = it.f3; intr = it.irq; mie = it.en;
      @(negedge CLK);
      checks++;
      if (outs !== it.exp) begin
        errors++;
        $display("FAIL %s: outputs %b, expected %b", it.name, outs, it.exp);
      end
    end
  endtask

  // Picks up in EXEC of an ADD; previous task left us in FETCH.
  task automatic test_intr_masked();
    item_t it;
    push(1, OP_ADD,  3'd0, 0, 0, E_ALU,   "m_add_exec");
    push(1, OP_ADD,  3'd0, 1, 0, E_FETCH, "m_irq_fetch");
    push(1, OP_ADD,  3'd0, 0, 0, E_ALU,   "m_irq_exec");
    push(1, OP_ADDI, 3'd0, 0, 0, E_FETCH, "m_no_intr");
    push(1, OP_ADDI, 3'd0, 0, 1, E_ALU,   "m_mie_exec");
    push(1, OP_SYS,  3'd0, 0, 0, E_INTR,  "m_late_entry");
    push(1, OP_SYS,  3'd0, 0, 0, E_FETCH, "mret_fetch");
    push(1, OP_SYS,  3'd0, 0, 0, E_MRET,  "mret_exec");
    // irq pending across mret: taken after the next instruction
    push(1, OP_SYS,  3'd0, 1, 0, E_FETCH, "mret2_fetch");
    push(1, OP_SYS,  3'd0, 0, 0, E_MRET,  "mret2_exec");
    push(1, OP_ADDI, 3'd0, 0, 1, E_FETCH, "mret2_no_intr");
    push(1, OP_ADDI, 3'd0, 0, 1, E_ALU,   "after_mret_exec");
    push(1, OP_ADDI, 3'd0, 0, 1, E_INTR,  "after_mret_entry");
    push(1, OP_LW,   3'd2, 0, 0, E_FETCH, "m_lw_fetch");
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(posedge CLK); #1;
      RST_N = it.rst_n; opcode = it.op; func3 = it.f3; intr = it.irq; mie = it.en;
      @(negedge CLK);
      checks++;
      if (outs !== it.exp) begin
        errors++;
        $display("FAIL %s: outputs %b, expected %b", it.name, outs, it.exp);
      end
    end
  endtask

  // Picks up in EXEC of the LW fetched above, then drops RST_N mid-WB.
  task automatic test_async_reset();
    item_t it;
    push(1, OP_LW, 3'd2, 0, 0, E_LW, "ar_lw_exec");
    push(1, OP_LW, 3'd2, 0, 0, E_WB, "ar_lw_wb");
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(posedge CLK); #1;
      RST_N = it.rst_n; opcode = it.op; func3 = it.f3; intr = it.irq; mie = it.en;
      @(negedge CLK);
      checks++;
      if (outs !== it.exp) begin
        errors++;
        $display("FAIL %s: outputs %b, expected %b", it.name, outs, it.exp);
      end
    end
    #1 RST_N = 1'b0;
    #1;
    checks++;
    if (outs !== E_RST) begin
      errors++;
      $display("FAIL async_rst_mid_wb: outputs %b, expected %b", outs, E_RST);
    end
    push(0, OP_ADD, 3'd0, 0, 0, E_RST,   "ar_hold");
    push(1, OP_ADD, 3'd0, 0, 0, E_RST,   "ar_init_c0");
    push(1, OP_ADD, 3'd0, 0, 0, E_RST,   "ar_init_c1");
    push(1, OP_ADD, 3'd0, 0, 0, E_FETCH, "ar_fetch");
    push(1, OP_ADD, 3'd0, 0, 0, E_ALU,   "ar_exec");
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(posedge CLK); #1;
      RST_N = it.rst_n; opcode = it.op; func3 = it.f3; intr = it.irq; mie = it.en;
      @(negedge CLK);
      checks++;
      if (outs !== it.exp) begin
        errors++;
        $display("FAIL %s: outputs %b, expected %b", it.name, outs, it.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi_lw();
    test_sw_beq_csr();
    test_intr_enabled();
    test_intr_masked();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
